// File: rtl/ucsbece154b_mem_arbiter_if.sv
// Bus bundle between the two cache refill engines, the SDRAM read port and the arbiter.
// The arbiter takes the slave view; the surrounding system drives the master view.
interface ucsbece154b_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  IReadRequest;
  logic [ADDR_WIDTH-1:0] IReadAddress;
  logic [DATA_WIDTH-1:0] IDataIn;
  logic                  IDataReady;
  logic                  DReadRequest;
  logic [ADDR_WIDTH-1:0] DReadAddress;
  logic [DATA_WIDTH-1:0] DDataIn;
  logic                  DDataReady;
  logic                  MemReadRequest;
  logic [ADDR_WIDTH-1:0] MemReadAddress;
  logic [DATA_WIDTH-1:0] MemDataIn;
  logic                  MemDataReady;
  logic                  Busy;
  logic                  GrantD;

  modport slave (
    input  IReadRequest, IReadAddress, DReadRequest, DReadAddress,
    input  MemDataIn, MemDataReady,
    output IDataIn, IDataReady, DDataIn, DDataReady,
    output MemReadRequest, MemReadAddress, Busy, GrantD
  );

  modport master (
    output IReadRequest, IReadAddress, DReadRequest, DReadAddress,
    output MemDataIn, MemDataReady,
    input  IDataIn, IDataReady, DDataIn, DDataReady,
    input  MemReadRequest, MemReadAddress, Busy, GrantD
  );
endinterface

// File: rtl/ucsbece154b_mem_arbiter.sv
// Shares the SDRAM read port between I-cache and D-cache refills: one aligned burst per grant.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default build gives dcache fixed priority.
module ucsbece154b_mem_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  ucsbece154b_mem_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = CNT_W + 2;
  localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = {{(ADDR_WIDTH-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t                state, state_next;
  logic                  grant_d, grant_d_next;
  logic [ADDR_WIDTH-1:0] addr, addr_next;
  logic [CNT_W-1:0]      beat_cnt, beat_cnt_next;
  logic                  dropped, dropped_next;
  logic                  pick_d;
  logic                  owner_req;
  logic                  beat_fwd;

  // Tie break between simultaneous requests; a lone request always wins.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    pick_d = bus.DReadRequest && (!bus.IReadRequest || !grant_d);
`else
    pick_d = bus.DReadRequest;
`endif
  end

  // A withdrawn owner stays muted until the burst drains, even if it re-raises its request.
  always_comb begin
    owner_req = grant_d ? bus.DReadRequest : bus.IReadRequest;
    beat_fwd  = (state == BURST) && bus.MemDataReady && owner_req && !dropped;
  end

  // Next-state and datapath update for the IDLE/ISSUE/BURST sequence.
  always_comb begin
    state_next    = state;
    grant_d_next  = grant_d;
    addr_next     = addr;
    beat_cnt_next = beat_cnt;
    dropped_next  = dropped;
    case (state)
      IDLE: begin
        if (bus.IReadRequest || bus.DReadRequest) begin
          state_next    = ISSUE;
          grant_d_next  = pick_d;
          addr_next     = (pick_d ? bus.DReadAddress : bus.IReadAddress) & BLOCK_MASK;
          beat_cnt_next = {CNT_W{1'b0}};
          dropped_next  = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        state_next = BURST;
      end
      BURST: begin
        dropped_next = dropped || !owner_req;
        if (bus.MemDataReady) begin
          if (beat_cnt == LAST_BEAT) begin
            state_next    = IDLE;
            beat_cnt_next = {CNT_W{1'b0}};
          end else begin
            beat_cnt_next = beat_cnt + 1'b1;
          end
        end else begin
          beat_cnt_next = beat_cnt;
        end
      end
      default: begin
        state_next    = IDLE;
        beat_cnt_next = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers; reset drops any burst in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_d  <= 1'b0;
      addr     <= {ADDR_WIDTH{1'b0}};
      beat_cnt <= {CNT_W{1'b0}};
      dropped  <= 1'b0;
    end else begin
      state    <= state_next;
      grant_d  <= grant_d_next;
      addr     <= addr_next;
      beat_cnt <= beat_cnt_next;
      dropped  <= dropped_next;
    end
  end

  assign bus.MemReadRequest = (state == ISSUE);
  assign bus.MemReadAddress = addr;
  assign bus.Busy           = (state != IDLE);
  assign bus.GrantD         = grant_d;
  assign bus.IDataIn        = bus.MemDataIn;
  assign bus.DDataIn        = bus.MemDataIn;
  assign bus.IDataReady     = beat_fwd && !grant_d;
  assign bus.DDataReady     = beat_fwd && grant_d;
endmodule
